// File: rtl/rom_download_bridge.sv
// Bridges the HPS ioctl byte stream into SDRAM-word writes over a toggle handshake,
// with a side path that captures DIP-switch bytes.
module rom_download_bridge #(
  parameter int DATA_BYTES = 2,
  parameter int ADDR_W     = 24,
  parameter int ROM_INDEX  = 0,
  parameter int DIP_INDEX  = 254,
  parameter int DIP_BYTES  = 8,
  parameter int SWAP       = 0
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic [7:0]              ioctl_index,
  input  logic                    ioctl_wr,
  input  logic [24:0]             ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic                    ioctl_wait,
  output logic [ADDR_W-1:0]       sdr_addr,
  output logic [8*DATA_BYTES-1:0] sdr_din,
  output logic [DATA_BYTES-1:0]   sdr_be,
  output logic                    sdr_req,
  input  logic                    sdr_ack,
  output logic [8*DIP_BYTES-1:0]  dip_sw,
  output logic [24:0]             bytes_loaded,
  output logic                    dl_done
);

  localparam int LANE_W = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam logic [LANE_W-1:0] TOP_LANE = LANE_W'(DATA_BYTES - 1);
  localparam logic [7:0] ROM_IDX = 8'(ROM_INDEX);
  localparam logic [7:0] DIP_IDX = 8'(DIP_INDEX);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FILL     = 3'd1;
  localparam logic [2:0] S_ISSUE    = 3'd2;
  localparam logic [2:0] S_WAIT_ACK = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;

  logic [2:0]              state;
  logic                    drain_flag;
  logic                    pend_vld;
  logic                    pend_top;
  logic [7:0]              pend_byte;
  logic [LANE_W-1:0]       pend_lane;
  logic [ADDR_W-1:0]       pend_addr;

  // These survive reset_n, so they only rely on their power-up value.
  logic                    dl_prev = 1'b0;
  logic                    dl_rom  = 1'b0;
  logic [24:0]             bytes_q = '0;
  logic [8*DIP_BYTES-1:0]  dip_q   = '0;

  logic [LANE_W-1:0]       addr_lane;
  logic [LANE_W-1:0]       phys_lane;
  logic [ADDR_W-1:0]       word_addr;
  logic                    addr_top;
  logic                    rom_wr;
  logic                    dip_wr;
  logic                    dl_rise;
  logic                    dl_fall;
  logic                    idle_fill;
  logic                    buf_used;
  logic                    split;
  logic                    ack_seen;
  logic                    drain_now;
  logic                    take_now;
  logic                    take_pend;

  assign addr_lane = LANE_W'(ioctl_addr % 25'(DATA_BYTES));
  assign phys_lane = (SWAP != 0) ? TOP_LANE - addr_lane : addr_lane;
  assign word_addr = ADDR_W'(ioctl_addr / 25'(DATA_BYTES));
  assign addr_top  = (addr_lane == TOP_LANE);

  assign rom_wr    = ioctl_wr && !ioctl_wait && (ioctl_index == ROM_IDX);
  assign dip_wr    = ioctl_wr && !ioctl_wait && (ioctl_index == DIP_IDX);
  assign dl_rise   = ioctl_download && !dl_prev;
  assign dl_fall   = !ioctl_download && dl_prev && dl_rom;
  assign idle_fill = (state == S_IDLE) || (state == S_FILL);
  assign buf_used  = |sdr_be;
  assign split     = buf_used && (word_addr != sdr_addr);
  assign ack_seen  = (state == S_WAIT_ACK) && (sdr_ack == sdr_req);
  assign drain_now = drain_flag || dl_fall;
  assign take_now  = reset_n && idle_fill && !dl_fall && rom_wr && !split;
  assign take_pend = reset_n && ack_seen && pend_vld;

  assign bytes_loaded = bytes_q;
  assign dip_sw       = dip_q;

  always_ff @(posedge clk_sys) begin
    dl_prev <= ioctl_download;
    if (dl_rise) dl_rom <= (ioctl_index == ROM_IDX);
    if (dl_rise && (ioctl_index == ROM_IDX)) bytes_q <= '0;
    else if (take_now || take_pend) bytes_q <= bytes_q + 25'd1;
    if (dip_wr) begin
      for (int k = 0; k < DIP_BYTES; k++) begin
        if (ioctl_addr == 25'(k)) dip_q[8*k +: 8] <= ioctl_dout;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      ioctl_wait <= 1'b0;
      sdr_be     <= '0;
      sdr_addr   <= '0;
      sdr_din    <= '0;
      dl_done    <= 1'b0;
      pend_vld   <= 1'b0;
      drain_flag <= 1'b0;
      sdr_req    <= sdr_ack;
    end else begin
      dl_done <= 1'b0;
      case (state)
        S_IDLE, S_FILL: begin
          if (dl_fall) begin
            if (buf_used) begin
              state      <= S_DRAIN;
              ioctl_wait <= 1'b1;
              drain_flag <= 1'b1;
            end else begin
              dl_done <= 1'b1;
              state   <= S_IDLE;
            end
          end else if (rom_wr) begin
            state <= S_FILL;
            if (split) begin
              // Byte for a different word waits here until the partial word is out.
              pend_vld   <= 1'b1;
              pend_byte  <= ioctl_dout;
              pend_lane  <= phys_lane;
              pend_top   <= addr_top;
              pend_addr  <= word_addr;
              state      <= S_ISSUE;
              ioctl_wait <= 1'b1;
            end else begin
              sdr_din[8*phys_lane +: 8] <= ioctl_dout;
              sdr_be[phys_lane]         <= 1'b1;
              sdr_addr                  <= word_addr;
              if (addr_top) begin
                state      <= S_ISSUE;
                ioctl_wait <= 1'b1;
              end
            end
          end
        end
        S_ISSUE, S_DRAIN: begin
          if (dl_fall) drain_flag <= 1'b1;
          sdr_req <= ~sdr_req;
          state   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (dl_fall) drain_flag <= 1'b1;
          if (ack_seen) begin
            sdr_din <= '0;
            sdr_be  <= '0;
            if (pend_vld) begin
              pend_vld                  <= 1'b0;
              sdr_din[8*pend_lane +: 8] <= pend_byte;
              sdr_be[pend_lane]         <= 1'b1;
              sdr_addr                  <= pend_addr;
              if (pend_top) state <= S_ISSUE;
              else if (drain_now) state <= S_DRAIN;
              else begin
                state      <= S_FILL;
                ioctl_wait <= 1'b0;
              end
            end else if (drain_now) begin
              drain_flag <= 1'b0;
              dl_done    <= 1'b1;
              state      <= S_IDLE;
              ioctl_wait <= 1'b0;
            end else begin
              state      <= S_FILL;
              ioctl_wait <= 1'b0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_download_bridge.sv
// Directed bench: a 2-byte-word bridge on index 0 and a 4-byte swapped bridge on index 1
// share one ioctl stream; each has its own hand-driven sdr_ack.
module tb_rom_download_bridge;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;

  logic        wait2, req2, ack2, done2;
  logic [23:0] addr2;
  logic [15:0] din2;
  logic [1:0]  be2;
  logic [63:0] dip2;
  logic [24:0] loaded2;

  logic        wait4, req4, ack4, done4;
  logic [23:0] addr4;
  logic [31:0] din4;
  logic [3:0]  be4;
  logic [63:0] dip4;
  logic [24:0] loaded4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rom_download_bridge #(
    .DATA_BYTES(2), .ADDR_W(24), .ROM_INDEX(0), .DIP_INDEX(254), .DIP_BYTES(8), .SWAP(0)
  ) u_dut (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(wait2), .sdr_addr(addr2), .sdr_din(din2),
    .sdr_be(be2), .sdr_req(req2), .sdr_ack(ack2), .dip_sw(dip2),
    .bytes_loaded(loaded2), .dl_done(done2)
  );

  rom_download_bridge #(
    .DATA_BYTES(4), .ADDR_W(24), .ROM_INDEX(1), .DIP_INDEX(253), .DIP_BYTES(8), .SWAP(1)
  ) u_dut4 (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(wait4), .sdr_addr(addr4), .sdr_din(din4),
    .sdr_be(be4), .sdr_req(req4), .sdr_ack(ack4), .dip_sw(dip4),
    .bytes_loaded(loaded4), .dl_done(done4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] idx, input logic [24:0] a, input logic [7:0] d);
    @(negedge clk);
    ioctl_index = idx;
    ioctl_addr  = a;
    ioctl_dout  = d;
    ioctl_wr    = 1'b1;
    @(negedge clk);
    ioctl_wr    = 1'b0;
  endtask

  task automatic set_download(input logic [7:0] idx, input logic lvl);
    @(negedge clk);
    ioctl_index    = idx;
    ioctl_download = lvl;
  endtask

  task automatic wait_req(input bit four);
    int n = 0;
    while (((four ? req4 : req2) == (four ? ack4 : ack2)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(four ? "req4_seen" : "req2_seen", 64'(n < 40), 64'd1);
  endtask

  task automatic give_ack(input bit four);
    @(negedge clk);
    if (four) ack4 = ~ack4;
    else ack2 = ~ack2;
    @(negedge clk);
  endtask

  task automatic count_done(input bit four, input string tag);
    int pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (four ? done4 : done2) pulses++;
      @(negedge clk);
    end
    chk(tag, 64'(pulses), 64'd1);
  endtask

  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = 8'd0; ack2 = 1'b0; ack4 = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_wait", 64'(wait2), 64'd0);
    chk("rst_be", 64'(be2), 64'd0);
    chk("rst_req", 64'(req2), 64'd0);
    chk("rst_done", 64'(done2), 64'd0);
    chk("rst_loaded", 64'(loaded2), 64'd0);
    chk("rst_dip", dip2, 64'd0);

    // Full word, ignored write during wait, then odd-length drain.
    set_download(8'd0, 1'b1);
    send_byte(8'd0, 25'd0, 8'h11);
    chk("lane0_be", 64'(be2), 64'd1);
    chk("lane0_wait", 64'(wait2), 64'd0);
    send_byte(8'd0, 25'd1, 8'h22);
    chk("full_wait", 64'(wait2), 64'd1);
    wait_req(1'b0);
    chk("full_addr", 64'(addr2), 64'd0);
    chk("full_din", 64'(din2), 64'h2211);
    chk("full_be", 64'(be2), 64'd3);
    send_byte(8'd0, 25'd3, 8'h99);
    chk("viol_din", 64'(din2), 64'h2211);
    chk("viol_loaded", 64'(loaded2), 64'd2);
    chk("hold_wait", 64'(wait2), 64'd1);
    give_ack(1'b0);
    chk("ack_wait", 64'(wait2), 64'd0);
    chk("ack_be", 64'(be2), 64'd0);
    send_byte(8'd0, 25'd2, 8'h33);
    set_download(8'd0, 1'b0);
    wait_req(1'b0);
    chk("drain_addr", 64'(addr2), 64'd1);
    chk("drain_be", 64'(be2), 64'd1);
    chk("drain_din", 64'(din2), 64'h0033);
    give_ack(1'b0);
    count_done(1'b0, "drain_done");
    chk("odd_loaded", 64'(loaded2), 64'd3);

    // Address jump forces a partial issue; the new byte lands after the ack.
    set_download(8'd0, 1'b1);
    @(negedge clk);
    chk("rise_clear", 64'(loaded2), 64'd0);
    send_byte(8'd0, 25'd10, 8'h55);
    send_byte(8'd0, 25'd20, 8'h66);
    wait_req(1'b0);
    chk("part_addr", 64'(addr2), 64'd5);
    chk("part_be", 64'(be2), 64'd1);
    chk("part_din", 64'(din2), 64'h0055);
    give_ack(1'b0);
    chk("pend_addr", 64'(addr2), 64'd10);
    chk("pend_be", 64'(be2), 64'd1);
    chk("pend_din", 64'(din2), 64'h0066);
    chk("pend_wait", 64'(wait2), 64'd0);
    chk("pend_loaded", 64'(loaded2), 64'd2);
    send_byte(8'd5, 25'd1, 8'h12);
    chk("other_idx_be", 64'(be2), 64'd1);
    chk("other_idx_loaded", 64'(loaded2), 64'd2);
    set_download(8'd0, 1'b0);
    wait_req(1'b0);
    give_ack(1'b0);
    count_done(1'b0, "pend_drain_done");

    // Empty download still reports completion.
    set_download(8'd0, 1'b1);
    set_download(8'd0, 1'b0);
    count_done(1'b0, "empty_done");
    chk("empty_loaded", 64'(loaded2), 64'd0);

    // Swapped 4-byte word on the second bridge.
    set_download(8'd1, 1'b1);
    send_byte(8'd1, 25'd4, 8'hA0);
    send_byte(8'd1, 25'd5, 8'hA1);
    send_byte(8'd1, 25'd6, 8'hA2);
    send_byte(8'd1, 25'd7, 8'hA3);
    wait_req(1'b1);
    chk("swap_addr", 64'(addr4), 64'd1);
    chk("swap_din", 64'(din4), 64'hA0A1A2A3);
    chk("swap_be", 64'(be4), 64'hF);
    chk("swap_other_req", 64'(req2), 64'(ack2));
    give_ack(1'b1);
    chk("swap_ack_wait", 64'(wait4), 64'd0);
    chk("swap_loaded", 64'(loaded4), 64'd4);
    set_download(8'd1, 1'b0);
    count_done(1'b1, "swap_done");

    // Reset while a request is outstanding.
    set_download(8'd0, 1'b1);
    send_byte(8'd0, 25'd0, 8'h77);
    send_byte(8'd0, 25'd1, 8'h88);
    wait_req(1'b0);
    chk("pre_rst_req", 64'(req2), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("post_rst_req", 64'(req2), 64'd0);
    chk("post_rst_wait", 64'(wait2), 64'd0);
    chk("post_rst_be", 64'(be2), 64'd0);
    chk("post_rst_din", 64'(din2), 64'd0);
    chk("post_rst_loaded", 64'(loaded2), 64'd2);
    repeat (10) @(negedge clk);
    chk("no_reissue", 64'(req2), 64'(ack2));
    set_download(8'd0, 1'b0);
    count_done(1'b0, "post_rst_done");

    // DIP capture, out-of-range address ignored, values kept through reset.
    send_byte(8'd254, 25'd0, 8'hFE);
    chk("dip_wait", 64'(wait2), 64'd0);
    send_byte(8'd254, 25'd1, 8'h7F);
    send_byte(8'd254, 25'd8, 8'hAA);
    chk("dip_b0", 64'(dip2[7:0]), 64'hFE);
    chk("dip_b1", 64'(dip2[15:8]), 64'h7F);
    chk("dip_all", dip2, 64'h7FFE);
    chk("dip_sdr_be", 64'(be2), 64'd0);
    chk("dip_req", 64'(req2), 64'(ack2));
    chk("dip_other", dip4, 64'd0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("dip_keep", dip2, 64'h7FFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
